dmem_access_ctrl: RTL and testbench

Data-memory access controller for the RV32I core, placed between the MEM pipeline stage and the data-memory bus. It accepts one load or store per instruction, using the decoded `mem_read`, `mem_write` and `inst_size` fields. It then runs a req/ack handshake on a word-addressed bus with byte enables, aligns and extends load data, detects misaligned and illegal accesses and bus timeouts, and stalls the pipeline until the access retires.

---
 rtl/dmem_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: MEM-stage load/store to a word-addressed req/ack bus,
// with byte-lane steering, load extension, alignment/illegal checks and bus timeout.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  inst_size,
   input  logic        load_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT} state_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_req_t;

   state_t      state, state_nxt;
   bus_req_t    breq, breq_nxt;
   logic [15:0] wait_cnt;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic        uns_q;

   logic        start, illegal, misaligned, timeout_hit;
   logic [31:0] load_val;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign start       = valid & (mem_read | mem_write);
   assign illegal     = (mem_read & mem_write) | (inst_size == 2'b11);
   assign misaligned  = ((inst_size == SZ_HALF) & addr[0]) |
                        ((inst_size == SZ_WORD) & (addr[1:0] != 2'b00));
   assign timeout_hit = (wait_cnt == TMO) & ~bus_ack;

   // Bus request fields for a legal access, steered onto the addressed byte lanes
   always_comb begin
      breq_nxt       = '0;
      breq_nxt.req   = 1'b1;
      breq_nxt.we    = mem_write;
      breq_nxt.addr  = {addr[31:2], 2'b00};
      case (inst_size)
         SZ_BYTE: begin
            breq_nxt.be    = 4'b0001 << addr[1:0];
            breq_nxt.wdata = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            breq_nxt.be    = addr[1] ? 4'b1100 : 4'b0011;
            breq_nxt.wdata = {2{wdata[15:0]}};
         end
         default: begin
            breq_nxt.be    = 4'b1111;
            breq_nxt.wdata = wdata;
         end
      endcase
   end

   // Load alignment uses the lane/size captured at accept time
   always_comb begin
      ld_byte  = bus_rdata[8*lane_q +: 8];
      ld_half  = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      load_val = bus_rdata;
      if (breq.we)
         load_val = '0;
      else if (size_q == SZ_BYTE)
         load_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      else if (size_q == SZ_HALF)
         load_val = {{16{~uns_q & ld_half[15]}}, ld_half};
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (illegal | misaligned) ? FAULT : BUSY;
         BUSY:    if (bus_ack) state_nxt = DONE;
                  else if (timeout_hit) state_nxt = FAULT;
         DONE:    state_nxt = IDLE;
         FAULT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      done  = 1'b0;
      fault = 1'b0;
      case (state)
         IDLE:    stall = start;
         BUSY:    stall = 1'b1;
         DONE:    done  = 1'b1;
         FAULT:   fault = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         breq        <= '0;
         wait_cnt    <= '0;
         rdata       <= '0;
         fault_cause <= '0;
         size_q      <= '0;
         lane_q      <= '0;
         uns_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               if (illegal)
                  fault_cause <= CAUSE_ILLEGAL;
               else if (misaligned)
                  fault_cause <= CAUSE_MISALIGN;
               else begin
                  breq     <= breq_nxt;
                  wait_cnt <= '0;
                  size_q   <= inst_size;
                  lane_q   <= addr[1:0];
                  uns_q    <= load_unsigned;
               end
            end
            BUSY: begin
               if (bus_ack) begin
                  breq.req <= 1'b0;
                  rdata    <= load_val;
               end else if (timeout_hit) begin
                  breq.req    <= 1'b0;
                  fault_cause <= CAUSE_TIMEOUT;
               end else
                  wait_cnt <= wait_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus_req   = breq.req;
   assign bus_we    = breq.we;
   assign bus_addr  = breq.addr;
   assign bus_be    = breq.be;
   assign bus_wdata = breq.wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed plan cases plus random accesses, each checked
// against a transaction-level model of expected bus fields, result and retire timing.
module tb_dmem_access_ctrl;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid, mem_read, mem_write, load_unsigned;
   logic [1:0]  inst_size;
   logic [31:0] addr, wdata;
   logic        stall, done, fault;
   logic [31:0] rdata;
   logic [1:0]  fault_cause;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   logic        bus_ack;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
      .inst_size(inst_size), .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
      .stall(stall), .done(done), .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One access from accept to retire; ack_k = cycle of the single ack pulse (0 = none)
   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic uns, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rbus, input int ack_k);
      int nb, ofs, e_done, e_fault, e_req_cnt, e_stall;
      logic [1:0]  e_cause;
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_rd, v;
      logic        bad;
      int cyc, done_c, fault_c, req_first, req_cnt, stall_cnt, unstable;
      logic [31:0] rd_obs;
      logic [1:0]  cause_obs;
      logic        stall_ret, fin;
      logic [31:0] f_addr, f_wd;
      logic [3:0]  f_be;
      logic        f_we;

      // expected behaviour from the access rules
      nb  = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
      ofs = int'(a % 4);
      bad = 1'b0; e_cause = 2'd0;
      if ((rd && wr) || sz == 2'd3) begin bad = 1'b1; e_cause = 2'd3; end
      else if ((sz == 2'd0 && ofs != 0) || (sz == 2'd1 && ofs % 2 != 0)) begin
         bad = 1'b1; e_cause = 2'd1;
      end
      e_be = 4'((32'd1 << nb) - 1) << ofs;
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
      v = rbus >> (8 * ofs);
      if (nb < 4) begin
         v = v & ((32'd1 << (8 * nb)) - 1);
         if (!uns && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 1);
      end
      e_rd = wr ? 32'd0 : v;
      if (bad) begin
         e_done = -1; e_fault = 1; e_req_cnt = 0; e_stall = 1;
      end else if (ack_k >= 1 && ack_k <= TMO + 1) begin
         e_done = ack_k + 1; e_fault = -1; e_req_cnt = ack_k; e_stall = ack_k + 1;
      end else begin
         e_done = -1; e_fault = TMO + 2; e_req_cnt = TMO + 1; e_stall = TMO + 2;
         e_cause = 2'd2;
      end

      @(posedge clk); #1;
      valid = 1'b1; mem_read = rd; mem_write = wr; inst_size = sz; load_unsigned = uns;
      addr = a; wdata = wd; bus_rdata = rbus; bus_ack = 1'b0;
      cyc = 0; done_c = -1; fault_c = -1; req_first = -1; req_cnt = 0; stall_cnt = 0;
      unstable = 0; fin = 1'b0; stall_ret = 1'b0; rd_obs = '0; cause_obs = '0;
      f_addr = '0; f_wd = '0; f_be = '0; f_we = 1'b0;
      while (!fin && cyc < 40) begin
         @(negedge clk);
         if (stall) stall_cnt++;
         if (bus_req) begin
            if (req_first < 0) begin
               req_first = cyc; f_addr = bus_addr; f_be = bus_be; f_wd = bus_wdata; f_we = bus_we;
            end else if (bus_addr !== f_addr || bus_be !== f_be || bus_wdata !== f_wd || bus_we !== f_we)
               unstable++;
            req_cnt++;
         end
         if (done || fault) begin
            fin = 1'b1; stall_ret = stall;
            if (done)  begin done_c = cyc;  rd_obs = rdata; end
            if (fault) begin fault_c = cyc; cause_obs = fault_cause; end
         end else begin
            @(posedge clk); #1;
            cyc++;
            bus_ack = (cyc == ack_k);
         end
      end
      bus_ack = 1'b0;

      check({tag, " done_cycle"}, done_c, e_done);
      check({tag, " fault_cycle"}, fault_c, e_fault);
      check({tag, " stall_cycles"}, stall_cnt, e_stall);
      check({tag, " stall_at_retire"}, {31'd0, stall_ret}, 32'd0);
      check({tag, " req_cycles"}, req_cnt, e_req_cnt);
      if (e_fault >= 0) check({tag, " fault_cause"}, {30'd0, cause_obs}, {30'd0, e_cause});
      if (e_done >= 0)  check({tag, " rdata"}, rd_obs, e_rd);
      if (!bad) begin
         check({tag, " req_first"}, req_first, 1);
         check({tag, " bus_addr"}, f_addr, a & ~32'd3);
         check({tag, " bus_be"}, {28'd0, f_be}, {28'd0, e_be});
         check({tag, " bus_we"}, {31'd0, f_we}, {31'd0, wr});
         if (wr) check({tag, " bus_wdata"}, f_wd, e_wd);
         check({tag, " bus_stable"}, unstable, 0);
      end
   endtask

   // Cycle with no memory instruction (optionally a stray ack): nothing may happen
   task automatic idle_cycle(input string tag, input logic is_valid, input logic stray_ack);
      @(posedge clk); #1;
      valid = is_valid; mem_read = 1'b0; mem_write = 1'b0; bus_ack = stray_ack;
      @(negedge clk);
      check({tag, " idle_activity"}, {28'd0, stall, bus_req, done, fault}, 32'd0);
      bus_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; inst_size = 2'd0;
      load_unsigned = 1'b0; addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctl", {27'd0, stall, done, fault, bus_req, bus_we}, 32'd0);
      check("reset_bus_addr", bus_addr, 32'd0);
      check("reset_bus_be_cause", {26'd0, bus_be, fault_cause}, 32'd0);
      check("reset_bus_wdata", bus_wdata, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      #1 reset = 1'b0;

      run_access("sb_1003", 1'b0, 1'b1, 2'd2, 1'b0, 32'h1003, 32'h000000AB, 32'h0, 3);
      run_access("lb_signed", 1'b1, 1'b0, 2'd2, 1'b0, 32'h2002, 32'h0, 32'h80FF7F01, 2);
      run_access("lbu", 1'b1, 1'b0, 2'd2, 1'b1, 32'h2002, 32'h0, 32'h80FF7F01, 1);
      run_access("lh_zero_wait", 1'b1, 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h80FF7F01, 1);
      run_access("lw_misaligned", 1'b1, 1'b0, 2'd0, 1'b0, 32'h3002, 32'h0, 32'h0, 1);
      run_access("rd_wr_illegal", 1'b1, 1'b1, 2'd0, 1'b0, 32'h3000, 32'h0, 32'h0, 1);
      run_access("size11_illegal", 1'b1, 1'b0, 2'd3, 1'b0, 32'h3001, 32'h0, 32'h0, 1);
      run_access("timeout", 1'b1, 1'b0, 2'd0, 1'b0, 32'h4000, 32'h0, 32'h12345678, 0);
      run_access("ack_at_limit", 1'b1, 1'b0, 2'd0, 1'b0, 32'h4004, 32'h0, 32'hCAFEF00D, TMO + 1);
      run_access("sw_b2b", 1'b0, 1'b1, 2'd0, 1'b0, 32'h4008, 32'hDEADBEEF, 32'h0, 1);
      idle_cycle("nonmem", 1'b1, 1'b1);
      idle_cycle("invalid", 1'b0, 1'b0);

      // reset while BUSY, then a late ack that must be ignored
      @(posedge clk); #1;
      valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; inst_size = 2'd0; addr = 32'h40; wdata = 32'h1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_busy_req", {31'd0, bus_req}, 32'd1);
      @(posedge clk); #1; reset = 1'b1; valid = 1'b0; mem_write = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_busy_ctl", {27'd0, stall, done, fault, bus_req, bus_we}, 32'd0);
      check("rst_busy_bus", {bus_addr[31:4], bus_addr[3:0] | bus_be}, 32'd0);
      check("rst_busy_wdata", bus_wdata, 32'd0);
      check("rst_busy_rdata", rdata, 32'd0);
      @(posedge clk); #1; reset = 1'b0; bus_ack = 1'b1;
      @(negedge clk);
      check("late_ack_c0", {30'd0, done, fault}, 32'd0);
      @(posedge clk); #1; bus_ack = 1'b0;
      @(negedge clk);
      check("late_ack_c1", {29'd0, done, fault, bus_req}, 32'd0);
      run_access("sw_after_rst", 1'b0, 1'b1, 2'd1, 1'b0, 32'h5002, 32'h0000BEEF, 32'h0, 2);

      for (int i = 0; i < 40; i++) begin
         logic r, w;
         int   sel;
         sel = int'($urandom_range(0, 9));
         r = (sel < 5) || (sel == 9);
         w = (sel >= 5);
         run_access("rand", r, w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, int'($urandom_range(0, 6)));
         if ($urandom_range(0, 3) == 0) idle_cycle("rand_idle", 1'($urandom_range(0, 1)), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
